ms_rr_capture_bridge: RTL

//  Parametrised master/slave section bridge. Arbitrates NUM_SLAVES slave input channels
//  (data + 1-cycle sync strobe) round-robin and adds the shared master input to the granted value.

---
 rtl/ms_rr_capture_bridge.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ms_rr_capture_bridge.sv
// ---------------------------------------------------------------------------
// ms_rr_capture_bridge
//
// Purpose
//   Master/slave section bridge. NUM_SLAVES slave channels each present a data
//   word and a one-cycle sync strobe. While in the ACCEPT section, the strobing
//   channels are arbitrated round-robin. The granted word is added to the
//   shared master operand, and the sum is pushed into a DEPTH-entry FIFO. The
//   master drains the FIFO over a notify/sync handshake.
//
//   A two-section FSM with hysteresis stops accepting when the FIFO fills. It
//   resumes once occupancy falls to LOW_WATER. Every strobe that does not turn
//   into a capture is counted in a saturating 16-bit drop counter.
//
// Handshake (master side)
//   m_out_notify is the valid and m_out_sync is the ready. A word transfers on
//   a rising clk edge where both are high. m_out is stable while m_out_notify
//   is high and m_out_sync is low. m_out_sync while m_out_notify is low has no
//   effect. Slave strobes have no ready: a strobe that is not captured on its
//   edge is lost and counted in drop_cnt.
//
// Parameters
//   WIDTH       data width of all data ports
//   NUM_SLAVES  number of slave channels (>=1)
//   DEPTH       FIFO entries (>=2, need not be a power of two)
//   LOW_WATER   level at/below which BACKPRESSURE returns to ACCEPT (< DEPTH)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   m_in         in   shared master operand added to the granted slave word
//   m_out        out  FIFO head value (0 while empty)
//   m_out_notify out  FIFO non-empty, m_out valid
//   m_out_sync   in   master takes m_out this cycle
//   s_in         in   slave data, channel i at [i*WIDTH +: WIDTH]
//   s_in_sync    in   per-channel one-cycle valid strobe
//   s_out        out  raw slave word of the last capture
//   shared_out   out  last captured sum (s_in[g] + m_in)
//   succ         out  a capture happened at the previous edge
//   section      out  FSM state: 0 = ACCEPT, 1 = BACKPRESSURE
//   level        out  FIFO occupancy
//   drop_cnt     out  saturating count of strobes that were not captured
// ---------------------------------------------------------------------------
module ms_rr_capture_bridge #(
    parameter int WIDTH      = 32,
    parameter int NUM_SLAVES = 2,
    parameter int DEPTH      = 4,
    parameter int LOW_WATER  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              m_in,
    output logic [WIDTH-1:0]              m_out,
    output logic                          m_out_notify,
    input  logic                          m_out_sync,
    input  logic [NUM_SLAVES*WIDTH-1:0]   s_in,
    input  logic [NUM_SLAVES-1:0]         s_in_sync,
    output logic [WIDTH-1:0]              s_out,
    output logic [WIDTH-1:0]              shared_out,
    output logic                          succ,
    output logic                          section,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic [15:0]                   drop_cnt
);

    localparam int PTR_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int CNT_W  = $clog2(NUM_SLAVES + 1);

    localparam logic [LVL_W-1:0]  DEPTH_L     = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LOW_WATER_L = LVL_W'(LOW_WATER);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_SLAVE  = PTR_W'(NUM_SLAVES - 1);

    typedef enum logic {
        ST_ACCEPT       = 1'b0,
        ST_BACKPRESSURE = 1'b1
    } section_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    section_t             r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [15:0]          r_drop_cnt;
    logic                 r_succ;
    logic [WIDTH-1:0]     r_s_out;
    logic [WIDTH-1:0]     r_shared_out;
    logic [WIDTH-1:0]     r_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic                 w_any_strobe;
    logic [PTR_W-1:0]     w_scan_idx;
    logic                 w_grant;
    logic [WIDTH-1:0]     w_slave_data;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_push;
    logic                 w_pop;
    logic [LVL_W-1:0]     w_level_next;
    logic [CNT_W-1:0]     w_sync_cnt;
    logic [CNT_W-1:0]     w_drop_inc;
    logic [16:0]          w_drop_sum;
    logic [15:0]          w_drop_next;
    logic [PTR_W-1:0]     w_rr_next;

    // Round-robin scan: the first strobing channel at or after r_rr_ptr,
    // wrapping around. Shifting the strobe vector keeps every select constant.
    always_comb begin
        logic [NUM_SLAVES-1:0] w_shifted;
        int                    scan;
        w_any_strobe = 1'b0;
        w_scan_idx   = '0;
        w_shifted    = '0;
        scan         = 0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            scan = int'(r_rr_ptr) + k;
            if (scan >= NUM_SLAVES) begin
                scan = scan - NUM_SLAVES;
            end
            w_shifted = s_in_sync >> scan;
            if (!w_any_strobe && w_shifted[0]) begin
                w_any_strobe = 1'b1;
                w_scan_idx   = PTR_W'(scan);
            end
        end
    end

    // Grants only exist in ACCEPT. A grant still moves the round-robin
    // pointer when the FIFO is full, so a blocked channel loses its turn.
    assign w_grant      = w_any_strobe && (r_state == ST_ACCEPT);
    assign w_slave_data = WIDTH'(s_in >> (int'(w_scan_idx) * WIDTH));
    assign w_sum        = w_slave_data + m_in;
    assign w_push       = w_grant && (r_level < DEPTH_L);
    assign w_pop        = m_out_sync && (r_level != '0);
    assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_rr_next    = (w_scan_idx == LAST_SLAVE) ? '0 : w_scan_idx + PTR_W'(1);

    // Every strobe bit that did not become the capture counts as a drop.
    always_comb begin
        w_sync_cnt = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_sync_cnt = w_sync_cnt + CNT_W'(s_in_sync[k]);
        end
    end

    assign w_drop_inc  = w_sync_cnt - CNT_W'(w_push);
    assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // -----------------------------------------------------------------------
    // Section FSM: the decision uses the level after this edge's push/pop.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_level_next == DEPTH_L) begin
                        r_state <= ST_BACKPRESSURE;
                    end
                end
                ST_BACKPRESSURE: begin
                    if (w_level_next <= LOW_WATER_L) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter pointer, capture registers, FIFO control, drop counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_cnt   <= '0;
            r_succ       <= 1'b0;
            r_s_out      <= '0;
            r_shared_out <= '0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= w_rr_next;
            end
            r_succ <= w_push;
            if (w_push) begin
                r_s_out      <= w_slave_data;
                r_shared_out <= w_sum;
                r_wr_ptr     <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_W'(1);
            end
            r_level    <= w_level_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    // FIFO storage needs no reset. The occupancy gate on m_out hides any
    // stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sum;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign m_out_notify = (r_level != '0);
    assign m_out        = m_out_notify ? r_mem[r_rd_ptr] : '0;
    assign s_out        = r_s_out;
    assign shared_out   = r_shared_out;
    assign succ         = r_succ;
    assign section      = r_state;
    assign level        = r_level;
    assign drop_cnt     = r_drop_cnt;

endmodule
